mux_4_1_arbiter: RTL and testbench

Round-robin arbiter that shares the 10-bit, 4-way mux datapath among four requesters. Each requester raises a request and presents a 10-bit word. The block grants one requester at a time and drives the mux select. It then registers the selected word onto a single output bus with a valid strobe. A grant may be held for a bounded burst, so one requester cannot starve the others.

---
 rtl/mux_4_1_arbiter.sv | 156 +++++++++++++++
 tb/tb_mux_4_1_arbiter.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mux_4_1_arbiter.sv
// mux_4_1_arbiter: round-robin arbiter that shares a 10-bit 4:1 mux among four
// requesters, with a bounded burst length per grant.
//   clk, rst        : clock and synchronous active-high reset
//   req[3:0]        : per-requester request
//   a, b, c, d      : 10-bit data words of requesters 0..3
//   gnt[3:0]        : registered one-hot grant (zero when idle)
//   s[1:0]          : registered mux select (holds when idle)
//   out, out_valid  : registered transferred word and its strobe
module mux_4_1_arbiter #(
  parameter int unsigned MAX_HOLD = 8
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] req,
  input  logic [9:0] a,
  input  logic [9:0] b,
  input  logic [9:0] c,
  input  logic [9:0] d,
  output logic [3:0] gnt,
  output logic [1:0] s,
  output logic [9:0] out,
  output logic       out_valid
);

  localparam logic [3:0] MAX_HOLD_C = 4'(MAX_HOLD);

  typedef enum logic {
    IDLE,
    GRANT
  } state_e;

  state_e     state_q, state_d;
  logic [1:0] owner_q, owner_d;
  logic [1:0] last_q, last_d;
  logic [3:0] hold_cnt_q, hold_cnt_d;
  logic [3:0] gnt_q, gnt_d;
  logic [1:0] s_q, s_d;
  logic [9:0] out_q, out_d;
  logic       out_valid_q, out_valid_d;

  logic       xfer;
  logic [3:0] owner_oh;
  logic [3:0] cand;
  logic [1:0] base;
  logic [1:0] idx;
  logic [1:0] winner;
  logic       found;
  logic       take;
  logic [3:0] cnt_inc;
  logic [9:0] mux_word;

  // Candidate set and scan origin: in IDLE scan all requests from last+1;
  // in GRANT scan from owner+1 with the owner masked out, which serves both
  // release (owner bit already low) and rotation (owner still requesting).
  always_comb begin
    owner_oh = 4'b0001 << owner_q;
    xfer     = |(gnt_q & req);
    cand     = (state_q == GRANT) ? (req & ~owner_oh) : req;
    base     = (state_q == GRANT) ? owner_q : last_q;
    found    = 1'b0;
    winner   = base;
    idx      = base;
    for (int unsigned k = 1; k <= 4; k++) begin
      idx = base + 2'(k);
      if (!found && cand[idx]) begin
        found  = 1'b1;
        winner = idx;
      end
    end
    cnt_inc = (hold_cnt_q == MAX_HOLD_C) ? MAX_HOLD_C : hold_cnt_q + 4'd1;
  end

  always_comb begin
    state_d    = state_q;
    owner_d    = owner_q;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    gnt_d      = gnt_q;
    s_d        = s_q;
    take       = 1'b0;

    unique case (state_q)
      IDLE: begin
        take = found;
      end
      GRANT: begin
        if (!req[owner_q]) begin
          last_d = owner_q;
          if (found) begin
            take = 1'b1;
          end else begin
            state_d    = IDLE;
            gnt_d      = '0;
            hold_cnt_d = '0;
          end
        end else if (cnt_inc == MAX_HOLD_C && found) begin
          last_d = owner_q;
          take   = 1'b1;
        end else begin
          hold_cnt_d = cnt_inc;
        end
      end
      default: begin
        state_d = IDLE;
        gnt_d   = '0;
      end
    endcase

    if (take) begin
      state_d    = GRANT;
      owner_d    = winner;
      s_d        = winner;
      gnt_d      = 4'b0001 << winner;
      hold_cnt_d = '0;
    end
  end

  always_comb begin
    unique case (s_q)
      2'd0:    mux_word = a;
      2'd1:    mux_word = b;
      2'd2:    mux_word = c;
      default: mux_word = d;
    endcase
    out_valid_d = xfer;
    out_d       = xfer ? mux_word : out_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      owner_q     <= '0;
      last_q      <= 2'd3;
      hold_cnt_q  <= '0;
      gnt_q       <= '0;
      s_q         <= '0;
      out_q       <= '0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      hold_cnt_q  <= hold_cnt_d;
      gnt_q       <= gnt_d;
      s_q         <= s_d;
      out_q       <= out_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign gnt       = gnt_q;
  assign s         = s_q;
  assign out       = out_q;
  assign out_valid = out_valid_q;

endmodule

// File: tb/tb_mux_4_1_arbiter.sv
// Testbench for mux_4_1_arbiter: directed scenarios plus random traffic,
// checked against a transfer-level reference model through a scoreboard.
module tb_mux_4_1_arbiter;

  localparam int MH = 8;

  logic       clk;
  logic       rst;
  logic [3:0] req;
  logic [9:0] a, b, c, d;
  logic [3:0] gnt;
  logic [1:0] s;
  logic [9:0] out;
  logic       out_valid;

  mux_4_1_arbiter #(.MAX_HOLD(MH)) dut (
    .clk       (clk),
    .rst       (rst),
    .req       (req),
    .a         (a),
    .b         (b),
    .c         (c),
    .d         (d),
    .gnt       (gnt),
    .s         (s),
    .out       (out),
    .out_valid (out_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] gnt;
    logic [1:0] s;
    logic       valid;
    logic [9:0] out;
  } exp_t;

  exp_t       exp_q[$];
  logic [9:0] data_q[$];
  int         n_checks = 0;
  int         n_fail   = 0;
  bit         started  = 1'b0;
  bit         done     = 1'b0;

  // Reference model state (transfer-level view of the arbiter)
  bit         m_grant;
  int         m_owner;
  int         m_cnt;
  int         m_last;
  logic [1:0] m_s;
  logic [9:0] m_out;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int pick(input logic [3:0] r, input int from);
    for (int k = 1; k <= 4; k++) begin
      int i;
      i = (from + k) % 4;
      if (r[i]) return i;
    end
    return from;
  endfunction

  task automatic model_step(input logic r, input logic [3:0] rq, input logic [9:0] w0,
                            input logic [9:0] w1, input logic [9:0] w2, input logic [9:0] w3);
    logic [9:0] w[4];
    logic [3:0] others;
    exp_t       e;
    bit         valid;
    w[0] = w0; w[1] = w1; w[2] = w2; w[3] = w3;
    valid = 1'b0;
    if (r) begin
      m_grant = 1'b0; m_owner = 0; m_cnt = 0; m_last = 3; m_s = '0; m_out = '0;
    end else begin
      if (m_grant && rq[m_owner]) begin
        valid = 1'b1;
        m_out = w[m_owner];
        data_q.push_back(w[m_owner]);
      end
      if (!m_grant) begin
        if (rq != 4'b0) begin
          m_owner = pick(rq, m_last);
          m_cnt   = 0;
          m_grant = 1'b1;
        end
      end else if (!rq[m_owner]) begin
        m_last = m_owner;
        if (rq != 4'b0) begin
          m_owner = pick(rq, m_owner);
          m_cnt   = 0;
        end else begin
          m_grant = 1'b0;
        end
      end else begin
        m_cnt  = (m_cnt + 1 > MH) ? MH : m_cnt + 1;
        others = rq & ~(4'b0001 << m_owner);
        if (m_cnt >= MH && others != 4'b0) begin
          m_last  = m_owner;
          m_owner = pick(others, m_owner);
          m_cnt   = 0;
        end
      end
      if (m_grant) m_s = 2'(m_owner);
    end
    e.gnt   = m_grant ? (4'b0001 << m_owner) : 4'b0000;
    e.s     = m_s;
    e.valid = valid;
    e.out   = m_out;
    exp_q.push_back(e);
    started = 1'b1;
  endtask

  task automatic cyc(input logic r, input logic [3:0] rq, input logic [9:0] wa,
                     input logic [9:0] wb, input logic [9:0] wc, input logic [9:0] wd);
    @(negedge clk);
    rst = r; req = rq; a = wa; b = wb; c = wc; d = wd;
    model_step(r, rq, wa, wb, wc, wd);
  endtask

  // Monitor: one expectation per clock edge, words popped on out_valid
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #2;
      if (!started || done) continue;
      if (exp_q.size() == 0) begin
        chk("exp_q_underflow", 32'd1, 32'd0);
        continue;
      end
      e = exp_q.pop_front();
      chk("gnt", 32'(gnt), 32'(e.gnt));
      chk("s", 32'(s), 32'(e.s));
      chk("out_valid", 32'(out_valid), 32'(e.valid));
      if (out_valid === 1'b1) begin
        if (data_q.size() == 0) chk("data_q_underflow", 32'd1, 32'd0);
        else                    chk("out_word", 32'(out), 32'(data_q.pop_front()));
      end else begin
        chk("out_hold", 32'(out), 32'(e.out));
      end
    end
  end

  initial begin
    logic [3:0] rr;
    logic [9:0] w[4];
    logic       r;
    rst = 1'b1; req = '0; a = '0; b = '0; c = '0; d = '0;

    // Reset then idle
    repeat (2) cyc(1'b1, 4'b0000, '0, '0, '0, '0);
    repeat (10) cyc(1'b0, 4'b0000, '0, '0, '0, '0);

    // Single requester
    repeat (20) cyc(1'b0, 4'b0100, '0, '0, 10'h2A5, '0);
    repeat (2) cyc(1'b0, 4'b0000, '0, '0, 10'h2A5, '0);

    // Full load
    cyc(1'b1, 4'b0000, '0, '0, '0, '0);
    repeat (70) cyc(1'b0, 4'b1111, 10'h001, 10'h002, 10'h003, 10'h004);
    repeat (2) cyc(1'b0, 4'b0000, 10'h001, 10'h002, 10'h003, 10'h004);

    // Early release of requester 1 after 3 transfers
    cyc(1'b1, 4'b0000, '0, '0, '0, '0);
    cyc(1'b0, 4'b0010, '0, 10'h111, '0, 10'h333);
    repeat (3) cyc(1'b0, 4'b1010, '0, 10'h111, '0, 10'h333);
    repeat (3) cyc(1'b0, 4'b1000, '0, 10'h111, '0, 10'h333);

    // Pointer wrap: requester 3 releases with requester 0 pending
    cyc(1'b1, 4'b0000, '0, '0, '0, '0);
    cyc(1'b0, 4'b1000, 10'h0AA, '0, '0, 10'h3CC);
    repeat (2) cyc(1'b0, 4'b1001, 10'h0AA, '0, '0, 10'h3CC);
    repeat (3) cyc(1'b0, 4'b0001, 10'h0AA, '0, '0, 10'h3CC);

    // Mid-burst reset on the 5th transfer of requester 2
    cyc(1'b1, 4'b0000, '0, '0, '0, '0);
    cyc(1'b0, 4'b0100, 10'h155, '0, 10'h2C2, '0);
    repeat (4) cyc(1'b0, 4'b0100, 10'h155, '0, 10'h2C2, '0);
    cyc(1'b1, 4'b0100, 10'h155, '0, 10'h2C2, '0);
    repeat (20) cyc(1'b0, 4'b0101, 10'h155, '0, 10'h2C2, '0);

    // Random traffic; a word only changes while its request is low
    rr = 4'b0000;
    for (int i = 0; i < 4; i++) w[i] = '0;
    for (int n = 0; n < 2000; n++) begin
      r = ($urandom_range(0, 199) == 0);
      for (int i = 0; i < 4; i++) begin
        if ($urandom_range(0, 7) == 0) rr[i] = ~rr[i];
        if (!rr[i]) w[i] = 10'($urandom);
      end
      cyc(r, rr, w[0], w[1], w[2], w[3]);
    end

    @(negedge clk);
    done = 1'b1;
    chk("exp_q_drained", 32'(exp_q.size()), 32'd0);
    chk("data_q_drained", 32'(data_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
